// File: rtl/dlf16_sign_issue_if.sv
// Request, sign-unit and response signals of the DLFloat16 sign issue stage.
// The stage connects through `slave`; whatever drives requests, models the sign unit and consumes responses uses `master`.
interface dlf16_sign_issue_if #(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [15:0]      req_a;
  logic [15:0]      req_b;
  logic [TAG_W-1:0] req_tag;

  logic [15:0]      op_in1;
  logic [15:0]      op_in2;
  logic [1:0]       op_sel;
  logic [15:0]      op_res;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [15:0]      rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_special;
  logic [CNT_W-1:0] done_cnt;

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_tag, op_res, rsp_ready,
    output req_ready, op_in1, op_in2, op_sel,
           rsp_valid, rsp_data, rsp_tag, rsp_special, done_cnt
  );

  modport master (
    output req_valid, req_op, req_a, req_b, req_tag, op_res, rsp_ready,
    input  req_ready, op_in1, op_in2, op_sel,
           rsp_valid, rsp_data, rsp_tag, rsp_special, done_cnt
  );
endinterface

// File: rtl/dlf16_sign_issue.sv
// Issue/return stage around the DLFloat16 sign unit.
// There is one operand register (S1) feeding the unit, and a 2-entry in-order response FIFO holds the unit's results.
module dlf16_sign_issue #(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  dlf16_sign_issue_if.slave   bus
);

  logic             s1_valid_q, s1_valid_d;
  logic [15:0]      s1_a_q, s1_a_d;
  logic [15:0]      s1_b_q, s1_b_d;
  logic [1:0]       s1_op_q, s1_op_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

  logic [15:0]      fifo_data_q [2];
  logic [15:0]      fifo_data_d [2];
  logic [TAG_W-1:0] fifo_tag_q  [2];
  logic [TAG_W-1:0] fifo_tag_d  [2];
  logic [1:0]       fifo_spec_q, fifo_spec_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [1:0]       fifo_count_q, fifo_count_d;
  logic [CNT_W-1:0] done_cnt_q, done_cnt_d;

  logic pop;
  logic s1_move;
  logic req_ready;
  logic accept;
  logic push;
  logic res_special;

  always_comb begin
    pop         = (fifo_count_q != 2'd0) && bus.rsp_ready;
    // A pop in the same cycle frees the slot that a full FIFO needs for S1.
    s1_move     = s1_valid_q && ((fifo_count_q < 2'd2) || pop);
    req_ready   = !flush && (!s1_valid_q || s1_move);
    accept      = bus.req_valid && req_ready;
    push        = s1_move && !flush;
    res_special = (bus.op_res[14:9] == 6'h3F) && (bus.op_res[8:0] == 9'h1FF);
  end

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_a_d       = s1_a_q;
    s1_b_d       = s1_b_q;
    s1_op_d      = s1_op_q;
    s1_tag_d     = s1_tag_q;
    fifo_data_d  = fifo_data_q;
    fifo_tag_d   = fifo_tag_q;
    fifo_spec_d  = fifo_spec_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    fifo_count_d = fifo_count_q;
    done_cnt_d   = done_cnt_q;

    // Pops count even when a flush discards the rest of the cycle's work.
    if (pop) begin
      done_cnt_d = done_cnt_q + CNT_W'(1);
    end

    if (flush) begin
      s1_valid_d   = 1'b0;
      rd_ptr_d     = 1'b0;
      wr_ptr_d     = 1'b0;
      fifo_count_d = 2'd0;
    end else begin
      if (accept) begin
        s1_valid_d = 1'b1;
        s1_a_d     = bus.req_a;
        s1_b_d     = bus.req_b;
        s1_op_d    = bus.req_op;
        s1_tag_d   = bus.req_tag;
      end else if (s1_move) begin
        s1_valid_d = 1'b0;
      end

      if (push) begin
        fifo_data_d[wr_ptr_q] = bus.op_res;
        fifo_tag_d[wr_ptr_q]  = s1_tag_q;
        fifo_spec_d[wr_ptr_q] = res_special;
        wr_ptr_d              = ~wr_ptr_q;
      end

      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end

      case ({push, pop})
        2'b10:   fifo_count_d = fifo_count_q + 2'd1;
        2'b01:   fifo_count_d = fifo_count_q - 2'd1;
        default: fifo_count_d = fifo_count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s1_op_q      <= '0;
      s1_tag_q     <= '0;
      fifo_data_q  <= '{default: '0};
      fifo_tag_q   <= '{default: '0};
      fifo_spec_q  <= '0;
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      fifo_count_q <= 2'd0;
      done_cnt_q   <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      s1_op_q      <= s1_op_d;
      s1_tag_q     <= s1_tag_d;
      fifo_data_q  <= fifo_data_d;
      fifo_tag_q   <= fifo_tag_d;
      fifo_spec_q  <= fifo_spec_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      fifo_count_q <= fifo_count_d;
      done_cnt_q   <= done_cnt_d;
    end
  end

  assign bus.req_ready   = req_ready;
  assign bus.op_in1      = s1_a_q;
  assign bus.op_in2      = s1_b_q;
  assign bus.op_sel      = s1_op_q;
  assign bus.rsp_valid   = (fifo_count_q != 2'd0);
  assign bus.rsp_data    = fifo_data_q[rd_ptr_q];
  assign bus.rsp_tag     = fifo_tag_q[rd_ptr_q];
  assign bus.rsp_special = fifo_spec_q[rd_ptr_q];
  assign bus.done_cnt    = done_cnt_q;

endmodule

// File: tb/tb_dlf16_sign_issue.sv
// Self-checking bench for dlf16_sign_issue.
// An occupancy/age model of in-flight requests is checked against the DUT every cycle, backed by literal expectations for the directed cases.
module tb_dlf16_sign_issue;

  logic clk = 1'b0;
  logic rst;
  logic flush;

  dlf16_sign_issue_if #(.TAG_W(4), .CNT_W(4)) bus ();

  dlf16_sign_issue #(.TAG_W(4), .CNT_W(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] sign_ref(input logic [1:0] op,
                                           input logic [15:0] a,
                                           input logic [15:0] b);
    case (op)
      2'd0:    return {~a[15], a[14:0]};
      2'd1:    return {a[15], b[14:0]};
      2'd2:    return {~a[15], b[14:0]};
      default: return {a[15] ^ b[15], b[14:0]};
    endcase
  endfunction

  // Behavioural model of the external sign unit.
  assign bus.op_res = sign_ref(bus.op_sel, bus.op_in1, bus.op_in2);

  typedef struct {
    logic [15:0] data;
    logic [3:0]  tag;
    logic        spec;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  exp_t        lit_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [3:0]  m_done = '0;
  logic [15:0] m_a = '0;
  logic [15:0] m_b = '0;
  logic [1:0]  m_op = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Per-cycle model: a request is visible 2 cycles after acceptance at the earliest, and at most 3 are held.
  always @(negedge clk) begin
    bit   exp_valid;
    bit   m_pop;
    bit   exp_ready;
    exp_t e;
    if (rst) begin
      q.delete();
      lit_q.delete();
      m_done = '0;
      m_a    = '0;
      m_b    = '0;
      m_op   = '0;
    end else begin
      exp_valid = 1'b0;
      if (q.size() > 0) exp_valid = (cyc - q[0].cyc >= 2);
      m_pop     = exp_valid && bus.rsp_ready;
      exp_ready = !flush && ((q.size() < 3) || m_pop);
      chk("rsp_valid", bus.rsp_valid, exp_valid);
      chk("req_ready", bus.req_ready, exp_ready);
      chk("done_cnt", bus.done_cnt, m_done);
      chk("op_in1", bus.op_in1, m_a);
      chk("op_in2", bus.op_in2, m_b);
      chk("op_sel", bus.op_sel, m_op);
      if (exp_valid) begin
        chk("rsp_data", bus.rsp_data, q[0].data);
        chk("rsp_tag", bus.rsp_tag, q[0].tag);
        chk("rsp_special", bus.rsp_special, q[0].spec);
      end
      if (m_pop) begin
        if (lit_q.size() > 0) begin
          chk("lit_data", bus.rsp_data, lit_q[0].data);
          chk("lit_tag", bus.rsp_tag, lit_q[0].tag);
          chk("lit_special", bus.rsp_special, lit_q[0].spec);
          void'(lit_q.pop_front());
        end
        void'(q.pop_front());
        m_done = m_done + 4'd1;
      end
      if (flush) begin
        q.delete();
        lit_q.delete();
      end else if (bus.req_valid && exp_ready) begin
        e.data = sign_ref(bus.req_op, bus.req_a, bus.req_b);
        e.tag  = bus.req_tag;
        e.spec = (e.data[14:0] == 15'h7FFF);
        e.cyc  = cyc;
        q.push_back(e);
        m_a  = bus.req_a;
        m_b  = bus.req_b;
        m_op = bus.req_op;
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic lit(input logic [15:0] d, input logic [3:0] t, input logic s);
    exp_t e;
    e.data = d;
    e.tag  = t;
    e.spec = s;
    e.cyc  = 0;
    lit_q.push_back(e);
  endtask

  task automatic send(input logic [1:0] op, input logic [15:0] a,
                      input logic [15:0] b, input logic [3:0] tag);
    bit got;
    got = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_tag   = tag;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.req_ready) got = 1'b1;
      tick();
      if (got) break;
    end
    bus.req_valid = 1'b0;
    chk("send_accepted", got, 1'b1);
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (q.size() == 0) break;
      tick();
    end
    chk("drain_empty", q.size(), 0);
  endtask

  // Holds req_valid for n cycles with a fresh request after every accept; returns the accept count.
  task automatic stream(input int n, inout logic [3:0] t, output int acc);
    bit got;
    acc = 0;
    bus.req_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      bus.req_op  = t[1:0];
      bus.req_a   = 16'h3C00 ^ {t, 12'h0A5};
      bus.req_b   = 16'h8A55 + {12'h0, t};
      bus.req_tag = t;
      @(negedge clk);
      got = bus.req_ready;
      tick();
      if (got) begin
        acc++;
        t = t + 4'd1;
      end
    end
  endtask

  initial begin
    int         acc;
    logic [3:0] t;
    logic [3:0] done_before;

    rst = 1'b1;
    flush = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_tag = '0;
    bus.rsp_ready = 1'b0;

    // Reset
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_req_ready", bus.req_ready, 1'b1);
    chk("reset_rsp_valid", bus.rsp_valid, 1'b0);
    chk("reset_done_cnt", bus.done_cnt, 4'd0);
    chk("reset_op_sel", bus.op_sel, 2'd0);
    chk("reset_rsp_data", bus.rsp_data, 16'h0000);
    tick();

    // Each op once
    bus.rsp_ready = 1'b1;
    lit(16'hBE00, 4'd0, 1'b0);
    lit(16'h3E40, 4'd1, 1'b0);
    lit(16'hBE40, 4'd2, 1'b0);
    lit(16'hBE40, 4'd3, 1'b0);
    for (int i = 0; i < 4; i++) send(i[1:0], 16'h3E00, 16'hBE40, i[3:0]);
    drain();
    idle(2);
    @(negedge clk);
    chk("done_after_ops", bus.done_cnt, 4'd4);
    tick();

    // Special flag
    lit(16'h7FFF, 4'd4, 1'b1);
    lit(16'hFDFF, 4'd5, 1'b0);
    send(2'd1, 16'h0000, 16'hFFFF, 4'd4);
    send(2'd0, 16'h7DFF, 16'h0000, 4'd5);
    drain();

    // Backpressure
    bus.rsp_ready = 1'b0;
    t = 4'd8;
    stream(8, t, acc);
    bus.req_valid = 1'b0;
    chk("bp_accepts", acc, 3);
    @(negedge clk);
    chk("bp_ready_low", bus.req_ready, 1'b0);
    tick();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("release_ready", bus.req_ready, 1'b1);
    tick();
    drain();

    // Flush with 3 entries held, no pop
    bus.rsp_ready = 1'b0;
    stream(6, t, acc);
    chk("flush_fill", acc, 3);
    done_before = m_done;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("flush_rsp_valid", bus.rsp_valid, 1'b0);
    chk("flush_req_ready", bus.req_ready, 1'b1);
    chk("flush_done_kept", bus.done_cnt, done_before);
    tick();

    // Flush coinciding with a pop still counts it
    send(2'd3, 16'h4000, 16'hC123, 4'd14);
    send(2'd2, 16'h1111, 16'h2222, 4'd15);
    idle(2);
    bus.rsp_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("flush_pop_counted", bus.done_cnt, done_before + 4'd1);
    tick();

    // New request after flush returns normally
    lit(16'hC000, 4'd6, 1'b0);
    send(2'd0, 16'h4000, 16'h1234, 4'd6);
    drain();

    // Reset mid-operation drops in-flight work
    bus.rsp_ready = 1'b0;
    send(2'd1, 16'h0001, 16'h0002, 4'd7);
    send(2'd2, 16'h0003, 16'h0004, 4'd8);
    rst = 1'b1;
    idle(2);
    bus.rsp_ready = 1'b1;
    rst = 1'b0;
    idle(4);

    // Counter wrap at CNT_W=4
    for (int i = 0; i < 17; i++) send(i[1:0], 16'h3000 + 16'(i), 16'hA000 - 16'(i), i[3:0]);
    drain();
    idle(2);
    @(negedge clk);
    chk("done_wrap", bus.done_cnt, 4'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dlf16_sign_issue.md
# dlf16_sign_issue

Pipelined issue/return stage that wraps the DLFloat16 sign-manipulation unit (negate, sign-inject, inverse-inject, xor-inject). It accepts operand requests over a valid/ready handshake and registers them onto the sign unit's `in1`/`in2`/`sel` inputs. It captures the unit's combinational result into a 2-entry response FIFO and returns results in order, with a tag, a special-value flag and a completion counter. One request per cycle is sustained when the consumer does not stall.

## Interface
- `TAG_W`, default 4: width of the request/response tag.
- `CNT_W`, default 16: width of the completion counter.
- `clk`, in, 1: single clock; all state is updated on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `flush`, in, 1: synchronous discard of all in-flight work.
- `req_valid`, in, 1: request present.
- `req_ready`, out, 1: stage can accept the request this cycle.
- `req_op`, in, 2: operation, using the sign unit's `sel` encoding.
  - 00: negate a.
  - 01: sign(a), magnitude(b).
  - 10: ~sign(a), magnitude(b).
  - 11: sign(a)^sign(b), magnitude(b).
- `req_a`, in, 16: operand a, DLFloat16 format, fields [15] sign, [14:9] exp, [8:0] mant.
- `req_b`, in, 16: operand b, DLFloat16 format.
- `req_tag`, in, TAG_W: opaque tag returned with the result.
- `op_in1`, out, 16: to the sign unit's `in1`; equals registered a.
- `op_in2`, out, 16: to the sign unit's `in2`; equals registered b.
- `op_sel`, out, 2: to the sign unit's `sel`; equals registered op.
- `op_res`, in, 16: sign unit's `out`; combinational function of `op_*`.
- `rsp_valid`, out, 1: response present.
- `rsp_ready`, in, 1: consumer accepts the response.
- `rsp_data`, out, 16: result.
- `rsp_tag`, out, TAG_W: tag of that result.
- `rsp_special`, out, 1: result exp==6'h3F and mant==9'h1FF (the DLFloat16 inf/NaN encoding).
- `done_cnt`, out, CNT_W: number of response handshakes since reset.

## Operation
- **Stage S1:** one register set holding `s1_valid`, a, b, op, tag. It drives `op_in1`, `op_in2` and `op_sel` directly. When `s1_valid`=0 these hold their last values.
- **Response FIFO:** 2 entries of {data, tag, special}. The write data is `op_res` sampled while S1 holds a valid entry. `special` is computed from `op_res` at write time.
- **S1 moves into the FIFO** (`s1_move`) when `s1_valid` and either `fifo_count`<2 or a response pop happens in the same cycle.
- **`req_ready`** = !`s1_valid` || `s1_move`. It is combinational and does not depend on `req_valid`.
- **Request accept** = `req_valid` && `req_ready`. On accept, S1 loads the request and `s1_valid`=1. On `s1_move` without an accept, `s1_valid`=0.
- **Pop** = `rsp_valid` && `rsp_ready`. `rsp_valid` = (`fifo_count`!=0). `rsp_data`, `rsp_tag` and `rsp_special` show the head entry and are stable while `rsp_valid`=1 and `rsp_ready`=0.
- **Simultaneous push and pop:**
  - FIFO full: the head leaves and the new entry takes the freed slot; count stays 2.
  - FIFO empty: no bypass. The entry is written and appears the next cycle.
- **`done_cnt`** increments by 1 on each pop and wraps from 2^CNT_W−1 to 0. `flush` does not clear it.
- **`flush`**: next cycle `s1_valid`=0 and `fifo_count`=0.
  - Any accept or pop in the flush cycle is discarded. `req_ready` is forced 0 during flush.
  - A pop that coincides with flush still counts in `done_cnt`.
- **`rst`** has priority over `flush`. Reset values:
  - `s1_valid`=0 and `fifo_count`=0, so `rsp_valid`=0 and `req_ready`=1 in the first cycle after reset.
  - `op_in1`=0, `op_in2`=0, `op_sel`=0.
  - `rsp_data`=0, `rsp_tag`=0, `rsp_special`=0, `done_cnt`=0.
- **Reset mid-operation** drops all in-flight requests silently; no responses are produced for them.
- **Ordering:** responses return in request order. No entry is ever dropped or duplicated outside flush or reset.

## Timing
- **Latency:** a request accepted at the edge ending cycle N drives `op_*` in N+1. Its response is valid in N+2 at the earliest, so the minimum latency is 2 cycles.
- **Throughput:** 1 per cycle with `rsp_ready` held at 1.
- **Stall:** with `rsp_ready`=0, at most 3 requests are held (S1 plus 2 FIFO entries). `req_ready` falls in the cycle after the third accept.
- **Release:** the first pop after a full stall re-asserts `req_ready` in that same cycle.

## Test plan
- **Reset:** assert `rst` for 2 cycles. Expect `req_ready`=1, `rsp_valid`=0, `done_cnt`=0 and `op_sel`=0.
- **Each op once**, with a=16'h3E00, b=16'hBE40, tags 0..3:
  - op 00 → 16'hBE00.
  - op 01 → 16'h3E40.
  - op 10 → 16'hBE40.
  - op 11 → 16'hBE40.
  - Each result arrives 2 cycles after its accept, in order; `done_cnt` reaches 4.
- **Special flag:** op 01, a=16'h0000, b=16'hFFFF → `rsp_data`=16'h7FFF with `rsp_special`=1. op 00, a=16'h7DFF → 16'hFDFF with `rsp_special`=0.
- **Backpressure:** `rsp_ready`=0 with continuous `req_valid`.
  - Exactly 3 accepts, then `req_ready`=0.
  - Holding `rsp_ready`=1 drains tags in order with no gap.
  - `req_ready` returns in the first pop cycle.
- **Flush:** with 3 entries held, assert `flush` for 1 cycle. The next cycle shows `rsp_valid`=0 and `req_ready`=1, `done_cnt` is unchanged, and a new request returns normally.
- **Wrap:** with CNT_W=4, complete 17 responses → `done_cnt`=1.
